// File: rtl/riscv_pkg.sv
// Shared core definitions: default data/address widths and the matching
// register-address and data-word types.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]           xlen_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard: flush > alloc > write-back clear > hold.
// Register 0 never reports busy.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 1,
  parameter int AW       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_vec
);
  import riscv_pkg::*;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Alloc is applied after the write-back clears so the new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (alloc_en) busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional same-cycle write-to-read
// bypass and a busy scoreboard for issue interlocking. x0 reads as zero.
module regfile_mp #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [$clog2(NUM_REGS)-1:0] alloc_addr,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy_vec
);
  import riscv_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic [XLEN-1:0] mem_d [NUM_REGS];

  // Ports are applied in ascending order so the highest-index port wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) mem_d[r] = mem_q[r];
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) mem_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  // A bypassed write only hides busy if no new producer is allocated to
  // the same register in that cycle.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    logic            hit;
    logic            bsy;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      val = mem_q[ra];
      hit = 1'b0;
      bsy = busy_vec[ra];
      if (BYPASS) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
            val = wr_data[w*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
        if (hit && !(alloc_en && (alloc_addr == ra))) bsy = 1'b0;
      end
      if (ra == '0) begin
        val = '0;
        bsy = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = val;
      rd_busy[i]              = bsy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing and a non-bypassing two-write-port instance
// share the same stimulus and are checked against hand-computed values.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        flush;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] busy_b, busy_n;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_mp #(.NUM_WR(2), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(busy_b)
  );

  regfile_mp #(.NUM_WR(2), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(busy_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    wr_addr  = '0;
    wr_data  = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_addr = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    nvec++;
    if (busy_b !== 32'h0 || busy_n !== 32'h0) begin
      nerr++; $display("FAIL reset_busy got %h/%h want 0", busy_b, busy_n);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      nvec++;
      if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0 || rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
        nerr++; $display("FAIL reset_read x%0d got %h/%h busy %b/%b want 0", a, rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
      end
    end
  endtask

  task automatic test_multi_write();
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5};
    wr_data = {32'h2222_2222, 32'h1111_1111};
    tick();
    idle();
    rd_addr = {5'd5, 5'd5};
    #1;
    nvec++;
    if (rd_data_b !== {2{32'h2222_2222}} || rd_data_n !== {2{32'h2222_2222}}) begin
      nerr++; $display("FAIL multi_write got %h/%h want 22222222", rd_data_b, rd_data_n);
    end
  endtask

  task automatic test_bypass();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hDEAD_BEEF};
    rd_addr = {5'd7, 5'd7};
    #1;
    nvec++;
    if (rd_data_b[31:0] !== 32'hDEAD_BEEF || rd_busy_b[0] !== 1'b0) begin
      nerr++; $display("FAIL bypass_on got %h busy %b want deadbeef busy 0", rd_data_b[31:0], rd_busy_b[0]);
    end
    nvec++;
    if (rd_data_n[31:0] !== 32'h0 || rd_busy_n[0] !== 1'b1) begin
      nerr++; $display("FAIL bypass_off got %h busy %b want 0 busy 1", rd_data_n[31:0], rd_busy_n[0]);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (rd_data_n[31:0] !== 32'hDEAD_BEEF || busy_b[7] !== 1'b0) begin
      nerr++; $display("FAIL bypass_next got %h busy %b want deadbeef busy 0", rd_data_n[31:0], busy_b[7]);
    end
    // Both ports hit x9: the port-1 value must be forwarded.
    wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h0000_00B2, 32'h0000_00A1};
    rd_addr = {5'd9, 5'd9};
    #1;
    nvec++;
    if (rd_data_b[31:0] !== 32'h0000_00B2) begin
      nerr++; $display("FAIL bypass_prio got %h want 000000b2", rd_data_b[31:0]);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (rd_data_n[31:0] !== 32'h0000_00B2) begin
      nerr++; $display("FAIL write_prio got %h want 000000b2", rd_data_n[31:0]);
    end
  endtask

  task automatic test_alloc_write_same();
    alloc_en = 1'b1; alloc_addr = 5'd10;
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd10;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h0000_0010};
    rd_addr = {5'd10, 5'd10};
    #1;
    nvec++;
    if (rd_busy_b[0] !== 1'b1) begin
      nerr++; $display("FAIL alloc_wr_rdbusy got %b want 1", rd_busy_b[0]);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (busy_b[10] !== 1'b1 || rd_data_n[31:0] !== 32'h0000_0010) begin
      nerr++; $display("FAIL alloc_wr_busy got %b data %h want 1 data 10", busy_b[10], rd_data_n[31:0]);
    end
  endtask

  task automatic test_busy_life();
    rd_addr = {5'd3, 5'd3};
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    idle();
    #1;
    nvec++;
    if (busy_b[3] !== 1'b1) begin
      nerr++; $display("FAIL busy_c1 got %b want 1", busy_b[3]);
    end
    tick();
    nvec++;
    if (busy_n[3] !== 1'b1) begin
      nerr++; $display("FAIL busy_c2 got %b want 1", busy_n[3]);
    end
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h0000_0333, 32'h0};
    #1;
    nvec++;
    if (rd_busy_n !== 2'b11 || rd_busy_b !== 2'b00) begin
      nerr++; $display("FAIL busy_wb_rd got %b/%b want 00/11", rd_busy_b, rd_busy_n);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (busy_b[3] !== 1'b0 || rd_data_n[63:32] !== 32'h0000_0333) begin
      nerr++; $display("FAIL busy_clear got %b data %h want 0 data 333", busy_b[3], rd_data_n[63:32]);
    end
  endtask

  task automatic test_flush();
    alloc_en = 1'b1; alloc_addr = 5'd8;
    tick();
    alloc_addr = 5'd11;
    tick();
    nvec++;
    if (busy_b !== 32'h0000_0D00) begin
      nerr++; $display("FAIL flush_pre got %h want 00000d00", busy_b);
    end
    flush = 1'b1; alloc_addr = 5'd4;
    tick();
    idle();
    #1;
    nvec++;
    if (busy_b !== 32'h0 || busy_n !== 32'h0) begin
      nerr++; $display("FAIL flush got %h/%h want 0", busy_b, busy_n);
    end
  endtask

  task automatic test_x0();
    wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFF_FFFF};
    alloc_en = 1'b1; alloc_addr = 5'd0;
    rd_addr = '0;
    #1;
    nvec++;
    if (rd_data_b !== 64'h0 || rd_busy_b !== 2'b00) begin
      nerr++; $display("FAIL x0_bypass got %h busy %b want 0", rd_data_b, rd_busy_b);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (rd_data_n !== 64'h0 || busy_b !== 32'h0) begin
      nerr++; $display("FAIL x0_state got %h busy %h want 0", rd_data_n, busy_b);
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h1234_5678};
    alloc_en = 1'b1; alloc_addr = 5'd13;
    tick();
    idle();
    rd_addr = {5'd13, 5'd12};
    #1;
    nvec++;
    if (rd_data_n[31:0] !== 32'h1234_5678 || busy_b[13] !== 1'b1) begin
      nerr++; $display("FAIL pre_rst got %h busy %b want 12345678 busy 1", rd_data_n[31:0], busy_b[13]);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0 || busy_b !== 32'h0 || busy_n !== 32'h0 || rd_busy_n !== 2'b00) begin
      nerr++; $display("FAIL async_rst got %h/%h busy %h/%h want 0", rd_data_b, rd_data_n, busy_b, busy_n);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd14}; wr_data = {32'h0, 32'hAAAA_AAAA};
    alloc_en = 1'b1; alloc_addr = 5'd14;
    tick();
    idle();
    rd_addr = {5'd14, 5'd12};
    #1;
    nvec++;
    if (rd_data_n !== 64'h0 || busy_n !== 32'h0) begin
      nerr++; $display("FAIL rst_ignore got %h busy %h want 0", rd_data_n, busy_n);
    end
    rst_n = 1'b1;
    #1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h0000_0055};
    tick();
    idle();
    #1;
    nvec++;
    if (rd_data_b[31:0] !== 32'h0000_0055 || rd_data_n[31:0] !== 32'h0000_0055) begin
      nerr++; $display("FAIL post_rst got %h/%h want 55", rd_data_b[31:0], rd_data_n[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_multi_write();
    test_bypass();
    test_alloc_write_same();
    test_busy_life();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
